// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Optional hold-limit feature: ARB_TIMEOUT_EN.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W = 3;
  localparam int CNT_W = 8;
  localparam int HOLD_CYCLES_DEF = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;
endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between requesters and rr_arb8.
// Optional hold-limit feature: ARB_TIMEOUT_EN.
interface rr_arb8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             rel;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, rel,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, rel,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arb8_prio_enc8.sv
// 8-to-3 priority encoder, lowest set index wins.
// Optional hold-limit feature: ARB_TIMEOUT_EN.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [ID_W-1:0]  idx,
  output logic             vld
);
  always_comb begin
    idx = '0;
    vld = |in;
    priority case (1'b1)
      in[0]:   idx = 3'd0;
      in[1]:   idx = 3'd1;
      in[2]:   idx = 3'd2;
      in[3]:   idx = 3'd3;
      in[4]:   idx = 3'd4;
      in[5]:   idx = 3'd5;
      in[6]:   idx = 3'd6;
      in[7]:   idx = 3'd7;
      default: idx = 3'd0;
    endcase
  end
endmodule

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with back-to-back handover.
// Optional hold-limit feature: ARB_TIMEOUT_EN.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  rr_arb8_if.slave bus
);
  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES out of range");
  end

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             to_q, to_d;

  logic             own_req;
  logic             nat_rel;
  logic             to_evt;
  logic             rel_evt;
  logic             new_gnt;
  logic [N_REQ-1:0] elig;
  logic [2*N_REQ-1:0] dbl;
  logic [ID_W-1:0]  enc_idx;
  logic             enc_vld;
  logic [ID_W-1:0]  win_id;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_lim;

  assign at_lim = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign to_evt = (state_q == GRANT) & at_lim & ~nat_rel;
`else
  assign to_evt = 1'b0;
`endif

  assign own_req = |(bus.req & gnt_q);
  assign nat_rel = bus.rel | ~own_req;
  assign rel_evt = nat_rel | to_evt;

  // ptr sits just past the owner, so the owner is searched last
  assign elig = to_evt ? (bus.req & ~gnt_q) : bus.req;
  assign dbl = {elig, elig} >> ptr_q;

  prio_enc8 u_enc (
    .in  (dbl[N_REQ-1:0]),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  assign win_id = enc_idx + ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    to_d    = 1'b0;
    new_gnt = 1'b0;
    unique case (state_q)
      IDLE: begin
        new_gnt = enc_vld;
      end
      GRANT: begin
        if (rel_evt) begin
          to_d    = to_evt;
          new_gnt = enc_vld;
          if (!enc_vld) begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
    if (new_gnt) begin
      state_d = GRANT;
      gnt_d   = N_REQ'(1) << win_id;
      id_d    = win_id;
      ptr_d   = win_id + 3'd1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (new_gnt || state_d == IDLE)
      cnt_d = '0;
    else if (state_q == GRANT && !rel_evt)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_rr_arb8.sv
// Directed and random checks for rr_arb8.
// Build with ARB_TIMEOUT_EN to exercise the hold limit (HOLD_CYCLES=4).
module tb_rr_arb8;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  rr_arb8_if bif ();

`ifdef ARB_TIMEOUT_EN
  localparam int HC = 4;
`else
  localparam int HC = 16;
`endif

  rr_arb8 #(.HOLD_CYCLES(HC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bif.req = '0;
    bif.rel = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bif.req = '0;
    bif.rel = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: got %h/%b expected 00/0",
               bif.gnt, bif.gnt_valid);
    end
    checks++;
    if (bif.gnt_id !== 3'd0 || bif.timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_id_to: got %0d/%b expected 0/0",
               bif.gnt_id, bif.timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bif.req = 8'h81;
    tick();
    checks++;
    if (bif.gnt !== 8'h01 || bif.gnt_id !== 3'd0 || bif.gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_first: got %h id %0d expected 01 id 0",
               bif.gnt, bif.gnt_id);
    end
    bif.rel = 1'b1;
    tick();
    checks++;
    if (bif.gnt !== 8'h80 || bif.gnt_id !== 3'd7) begin
      errors++;
      $display("FAIL basic_b2b: got %h id %0d expected 80 id 7",
               bif.gnt, bif.gnt_id);
    end
    bif.rel = 1'b0;
    bif.req = 8'h00;
    tick();
    checks++;
    if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got %h/%b expected 00/0",
               bif.gnt, bif.gnt_valid);
    end
    bif.req = 8'h81;
    tick();
    checks++;
    if (bif.gnt !== 8'h01) begin
      errors++;
      $display("FAIL basic_wrap: got %h expected 01", bif.gnt);
    end
    bif.req = 8'h00;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bif.req = 8'hFF;
    tick();
    checks++;
    if (bif.gnt_id !== 3'd0 || bif.gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_0: got id %0d v %b expected 0 v 1",
               bif.gnt_id, bif.gnt_valid);
    end
    bif.rel = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] e;
      e = 3'(k % 8);
      tick();
      checks++;
      if (bif.gnt_id !== e || bif.gnt_valid !== 1'b1 ||
          bif.gnt !== (8'h01 << e)) begin
        errors++;
        $display("FAIL b2b_seq%0d: got id %0d gnt %h expected id %0d",
                 k, bif.gnt_id, bif.gnt, e);
      end
    end
    bif.rel = 1'b0;
    bif.req = 8'h00;
    tick();
  endtask

  task automatic test_release_idle();
    do_reset();
    bif.req = 8'h08;
    tick();
    checks++;
    if (bif.gnt_id !== 3'd3 || bif.gnt !== 8'h08) begin
      errors++;
      $display("FAIL rel_own3: got %h id %0d expected 08 id 3",
               bif.gnt, bif.gnt_id);
    end
    bif.req = 8'h00;
    tick();
    checks++;
    if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0 || bif.gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL rel_drop: got %h/%b expected 00/0",
               bif.gnt, bif.gnt_valid);
    end
    for (int k = 0; k < 3; k++) begin
      bif.rel = 1'b1;
      tick();
      bif.rel = 1'b0;
      checks++;
      if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL rel_idle%0d: got %h expected 00", k, bif.gnt);
      end
    end
  endtask

  task automatic test_stable();
    bif.req = 8'h02;
    tick();
    checks++;
    if (bif.gnt !== 8'h02) begin
      errors++;
      $display("FAIL stable_gnt: got %h expected 02", bif.gnt);
    end
    bif.req = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bif.gnt !== 8'h02 || bif.gnt_id !== 3'd1) begin
        errors++;
        $display("FAIL stable_hold%0d: got %h expected 02", k, bif.gnt);
      end
    end
    bif.rel = 1'b1;
    tick();
    bif.rel = 1'b0;
    checks++;
    if (bif.gnt !== 8'h04 || bif.gnt_id !== 3'd2) begin
      errors++;
      $display("FAIL stable_next: got %h expected 04", bif.gnt);
    end
    bif.req = 8'h00;
    tick();
  endtask

  task automatic test_sole_rel();
    bif.req = 8'h20;
    tick();
    checks++;
    if (bif.gnt_id !== 3'd5) begin
      errors++;
      $display("FAIL sole_first: got %0d expected 5", bif.gnt_id);
    end
    bif.rel = 1'b1;
    tick();
    bif.rel = 1'b0;
    checks++;
    if (bif.gnt !== 8'h20 || bif.gnt_valid !== 1'b1 || bif.timeout !== 1'b0) begin
      errors++;
      $display("FAIL sole_regrant: got %h/%b expected 20/1",
               bif.gnt, bif.gnt_valid);
    end
    bif.req = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    bif.req = 8'h40;
    tick();
    checks++;
    if (bif.gnt_id !== 3'd6) begin
      errors++;
      $display("FAIL async_pre: got %0d expected 6", bif.gnt_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: got %h/%b expected 00/0",
               bif.gnt, bif.gnt_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bif.req = 8'h90;
    tick();
    checks++;
    if (bif.gnt_id !== 3'd4 || bif.gnt !== 8'h10) begin
      errors++;
      $display("FAIL async_ptr0: got id %0d expected 4", bif.gnt_id);
    end
    bif.req = 8'h00;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bif.req = 8'h05;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bif.gnt !== 8'h01 || bif.timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold%0d: got %h/%b expected 01/0",
                 k, bif.gnt, bif.timeout);
      end
    end
    tick();
    checks++;
    if (bif.gnt !== 8'h04 || bif.timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_revoke: got %h/%b expected 04/1",
               bif.gnt, bif.timeout);
    end
    tick();
    checks++;
    if (bif.gnt !== 8'h04 || bif.timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: got %h/%b expected 04/0",
               bif.gnt, bif.timeout);
    end
    do_reset();
    bif.req = 8'h01;
    for (int k = 0; k < 4; k++) tick();
    tick();
    checks++;
    if (bif.gnt !== 8'h00 || bif.gnt_valid !== 1'b0 || bif.timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_sole_idle: got %h/%b/%b expected 00/0/1",
               bif.gnt, bif.gnt_valid, bif.timeout);
    end
    tick();
    checks++;
    if (bif.gnt !== 8'h01 || bif.timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_sole_regrant: got %h/%b expected 01/0",
               bif.gnt, bif.timeout);
    end
    bif.req = 8'h00;
    tick();
  endtask
`else
  task automatic test_hold();
    do_reset();
    bif.req = 8'h01;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bif.gnt !== 8'h01 || bif.timeout !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: got %h/%b expected 01/0",
                 k, bif.gnt, bif.timeout);
      end
    end
    bif.req = 8'h00;
    tick();
  endtask
`endif

  task automatic test_random();
    int wait_n [8];
    logic [7:0] req_e;
    logic [7:0] prev;
    int worst;
    do_reset();
    for (int i = 0; i < 8; i++) wait_n[i] = 0;
    prev = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      req_e = 8'($urandom);
      if (n % 3 == 0) req_e = req_e & 8'($urandom);
      bif.req = req_e;
      bif.rel = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ((bif.gnt & (bif.gnt - 8'h01)) != 8'h00 ||
          bif.gnt_valid !== (|bif.gnt)) begin
        errors++;
        $display("FAIL rnd_onehot%0d: got %h/%b expected onehot",
                 n, bif.gnt, bif.gnt_valid);
      end
      checks++;
      if (bif.gnt_valid && bif.gnt !== (8'h01 << bif.gnt_id)) begin
        errors++;
        $display("FAIL rnd_id%0d: got id %0d gnt %h expected match",
                 n, bif.gnt_id, bif.gnt);
      end
      worst = 0;
      for (int i = 0; i < 8; i++) begin
        if (bif.gnt[i] || !req_e[i]) wait_n[i] = 0;
        else if (bif.gnt != prev && bif.gnt != 8'h00) wait_n[i]++;
        if (wait_n[i] > worst) worst = wait_n[i];
      end
      checks++;
      if (worst > 7) begin
        errors++;
        $display("FAIL rnd_starve%0d: got %0d expected <=7", n, worst);
      end
      prev = bif.gnt;
    end
    bif.req = 8'h00;
    bif.rel = 1'b0;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_release_idle();
    test_stable();
    test_sole_rel();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
